// File: rtl/ao_share_arbiter_if.sv
// Request/operand/result bundle shared between the requesters and the AND-OR unit.
interface ao_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ*W-1:0] c_in;
  logic [N_REQ*W-1:0] d_in;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       y;
  logic [ID_W-1:0]    y_id;
  logic               y_valid;
  logic               y_ready;
  logic               busy;

  modport slave (
    input  req, a_in, b_in, c_in, d_in, y_ready,
    output gnt, y, y_id, y_valid, busy
  );

  modport master (
    output req, a_in, b_in, c_in, d_in, y_ready,
    input  gnt, y, y_id, y_valid, busy
  );
endinterface

// File: rtl/ao_share_arbiter.sv
// Round-robin shared two-stage y = (a & b) | (c & d) unit with stallable output.
module ao_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int ID_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ao_share_arbiter_if.slave bus
);

  logic              s1_valid_q, s1_valid_d;
  logic [W-1:0]      tmp1_q, tmp1_d;
  logic [W-1:0]      tmp2_q, tmp2_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              y_valid_q, y_valid_d;
  logic [W-1:0]      y_q, y_d;
  logic [ID_W-1:0]   y_id_q, y_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              ld1, ld2;
  logic              grant;
  logic [ID_W-1:0]   gidx;
  logic [N_REQ-1:0]  gnt;
  logic [W-1:0]      sel_a, sel_b, sel_c, sel_d;

  assign ld2 = !y_valid_q || bus.y_ready;
  assign ld1 = !s1_valid_q || ld2;

  // Round-robin search starting at ptr; only when stage 1 can accept.
  always_comb begin
    int unsigned idx;
    int unsigned gsel;
    grant = 1'b0;
    gidx  = '0;
    gsel  = 0;
    idx   = 0;
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    sel_d = '0;
    if (ld1) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = (32'(ptr_q) + k) % N_REQ;
        if (!grant && bus.req[idx]) begin
          grant = 1'b1;
          gsel  = idx;
          gidx  = ID_W'(idx);
          sel_a = bus.a_in[idx*W +: W];
          sel_b = bus.b_in[idx*W +: W];
          sel_c = bus.c_in[idx*W +: W];
          sel_d = bus.d_in[idx*W +: W];
        end
      end
    end
    gnt   = (rst_n && grant) ? (N_REQ'(1) << gidx) : '0;
    ptr_d = grant ? ID_W'((gsel + 1) % N_REQ) : ptr_q;
  end

  // Pipeline next-state: stage 1 loads on ld1, stage 2 on ld2, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    tmp1_d     = tmp1_q;
    tmp2_d     = tmp2_q;
    s1_id_d    = s1_id_q;
    y_valid_d  = y_valid_q;
    y_d        = y_q;
    y_id_d     = y_id_q;
    if (ld1) begin
      s1_valid_d = grant;
      tmp1_d     = sel_a & sel_b;
      tmp2_d     = sel_c & sel_d;
      s1_id_d    = gidx;
    end
    if (ld2) begin
      y_valid_d = s1_valid_q;
      y_d       = tmp1_q | tmp2_q;
      y_id_d    = s1_id_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      tmp1_q     <= '0;
      tmp2_q     <= '0;
      s1_id_q    <= '0;
      y_valid_q  <= 1'b0;
      y_q        <= '0;
      y_id_q     <= '0;
      ptr_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      tmp1_q     <= tmp1_d;
      tmp2_q     <= tmp2_d;
      s1_id_q    <= s1_id_d;
      y_valid_q  <= y_valid_d;
      y_q        <= y_d;
      y_id_q     <= y_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.y       = y_q;
  assign bus.y_id    = y_id_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = s1_valid_q | y_valid_q;

endmodule
